sha256_compress_ctrl: RTL and testbench

Sequencer for one SHA-256 compression. It loads a 512-bit message block and a 256-bit chaining value. It then iterates the team's single-round SHA-256 node (a..h in and out, plus k and w) for 64 clock cycles, one round per cycle, and adds the result back into the chaining value. It sits between the miner's nonce/header front end and the double-hash wrapper, which instantiates it twice.

---
 rtl/sha256_compress_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sha256_compress_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression sequencer: loads one block and a chaining value, runs
// 64 rounds at one round per clock, then adds the working state back in.
module sha256_compress_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [5:0]    rnd_r;
    logic [31:0]   k_r;
    logic [31:0]   st_r   [0:7];
    logic [31:0]   hreg_r [0:7];
    logic [31:0]   wwin_r [0:15];
    logic          busy_r;
    logic          done_r;
    logic [255:0]  digest_r;
    logic [31:0]   t1_s;
    logic [31:0]   t2_s;
    logic [31:0]   wnew_s;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        case (idx)
            6'd0:  return 32'h428a2f98; 6'd1:  return 32'h71374491; 6'd2:  return 32'hb5c0fbcf; 6'd3:  return 32'he9b5dba5;
            6'd4:  return 32'h3956c25b; 6'd5:  return 32'h59f111f1; 6'd6:  return 32'h923f82a4; 6'd7:  return 32'hab1c5ed5;
            6'd8:  return 32'hd807aa98; 6'd9:  return 32'h12835b01; 6'd10: return 32'h243185be; 6'd11: return 32'h550c7dc3;
            6'd12: return 32'h72be5d74; 6'd13: return 32'h80deb1fe; 6'd14: return 32'h9bdc06a7; 6'd15: return 32'hc19bf174;
            6'd16: return 32'he49b69c1; 6'd17: return 32'hefbe4786; 6'd18: return 32'h0fc19dc6; 6'd19: return 32'h240ca1cc;
            6'd20: return 32'h2de92c6f; 6'd21: return 32'h4a7484aa; 6'd22: return 32'h5cb0a9dc; 6'd23: return 32'h76f988da;
            6'd24: return 32'h983e5152; 6'd25: return 32'ha831c66d; 6'd26: return 32'hb00327c8; 6'd27: return 32'hbf597fc7;
            6'd28: return 32'hc6e00bf3; 6'd29: return 32'hd5a79147; 6'd30: return 32'h06ca6351; 6'd31: return 32'h14292967;
            6'd32: return 32'h27b70a85; 6'd33: return 32'h2e1b2138; 6'd34: return 32'h4d2c6dfc; 6'd35: return 32'h53380d13;
            6'd36: return 32'h650a7354; 6'd37: return 32'h766a0abb; 6'd38: return 32'h81c2c92e; 6'd39: return 32'h92722c85;
            6'd40: return 32'ha2bfe8a1; 6'd41: return 32'ha81a664b; 6'd42: return 32'hc24b8b70; 6'd43: return 32'hc76c51a3;
            6'd44: return 32'hd192e819; 6'd45: return 32'hd6990624; 6'd46: return 32'hf40e3585; 6'd47: return 32'h106aa070;
            6'd48: return 32'h19a4c116; 6'd49: return 32'h1e376c08; 6'd50: return 32'h2748774c; 6'd51: return 32'h34b0bcb5;
            6'd52: return 32'h391c0cb3; 6'd53: return 32'h4ed8aa4a; 6'd54: return 32'h5b9cca4f; 6'd55: return 32'h682e6ff3;
            6'd56: return 32'h748f82ee; 6'd57: return 32'h78a5636f; 6'd58: return 32'h84c87814; 6'd59: return 32'h8cc70208;
            6'd60: return 32'h90befffa; 6'd61: return 32'ha4506ceb; 6'd62: return 32'hbef9a3f7; 6'd63: return 32'hc67178f2;
            default: return 32'h00000000;
        endcase
    endfunction

    // Round node and schedule expansion, fed by the pre-registered K word.
    always_comb begin
        t1_s   = st_r[7] + bsig1(st_r[4]) + ((st_r[4] & st_r[5]) ^ (~st_r[4] & st_r[6]))
               + k_r + wwin_r[0];
        t2_s   = bsig0(st_r[0]) + ((st_r[0] & st_r[1]) ^ (st_r[0] & st_r[2]) ^ (st_r[1] & st_r[2]));
        wnew_s = ssig1(wwin_r[14]) + wwin_r[9] + ssig0(wwin_r[1]) + wwin_r[0];
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = ROUND;
                else       state_next_s = IDLE;
            end
            ROUND: begin
                if (rnd_r == 6'd63) state_next_s = FINAL;
                else                state_next_s = ROUND;
            end
            FINAL:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            rnd_r    <= 6'd0;
            k_r      <= 32'h00000000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            digest_r <= 256'h0;
            for (int i = 0; i < 8; i++) begin
                st_r[i]   <= 32'h00000000;
                hreg_r[i] <= 32'h00000000;
            end
            for (int i = 0; i < 16; i++) begin
                wwin_r[i] <= 32'h00000000;
            end
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_r == FINAL);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rnd_r <= 6'd0;
                        k_r   <= k_rom(6'd0);
                        for (int i = 0; i < 8; i++) begin
                            st_r[i]   <= h_in[255 - 32*i -: 32];
                            hreg_r[i] <= h_in[255 - 32*i -: 32];
                        end
                        for (int i = 0; i < 16; i++) begin
                            wwin_r[i] <= block_in[511 - 32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    rnd_r   <= rnd_r + 6'd1;
                    k_r     <= k_rom(rnd_r + 6'd1);
                    st_r[0] <= t1_s + t2_s;
                    st_r[1] <= st_r[0];
                    st_r[2] <= st_r[1];
                    st_r[3] <= st_r[2];
                    st_r[4] <= st_r[3] + t1_s;
                    st_r[5] <= st_r[4];
                    st_r[6] <= st_r[5];
                    st_r[7] <= st_r[6];
                    for (int i = 0; i < 15; i++) begin
                        wwin_r[i] <= wwin_r[i+1];
                    end
                    wwin_r[15] <= wnew_s;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        digest_r[255 - 32*i -: 32] <= hreg_r[i] + st_r[i];
                    end
                end
                default: begin
                    rnd_r <= 6'd0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign digest_out = digest_r;

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Self-checking bench for sha256_compress_ctrl: known vectors plus random blocks
// compared against a whole-message-schedule reference model.
module tb_sha256_compress_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b1;
    logic [511:0] block_in = 512'h0;
    logic [255:0] h_in = 256'h0;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_compress_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .block_in   (block_in),
        .h_in       (h_in),
        .busy       (busy),
        .done       (done),
        .digest_out (digest_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hv);
        logic [31:0] w [0:63];
        logic [31:0] v [0:7];
        logic [31:0] s0, s1, t1, t2, ch, maj;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int j = 0; j < 8; j++) v[j] = hv[255 - 32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
            maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ch + KT[t] + w[t];
            t2  = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + maj;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = hv[255 - 32*j -: 32] + v[j];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job and let edge E0 sample it.
    task automatic launch(input logic [511:0] blk, input logic [255:0] hv);
        block_in = blk;
        h_in     = hv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Observe 80 edges after E0: first done latency, busy and done counts.
    task automatic watch(output int lat, output int busy_cnt, output int done_cnt);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        int dcnt;
        reset_n = 1'b0;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (digest_out !== 256'h0) begin n_fail++; $display("FAIL reset_digest: got %h want 0", digest_out); end
        reset_n = 1'b1;
        start   = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        n_cmp++; if (dcnt !== 0) begin n_fail++; $display("FAIL reset_idle_activity: got %0d cycles want 0", dcnt); end
    endtask

    task automatic test_vector(input logic [511:0] blk, input logic [255:0] want, input string name);
        int lat, bc, dc;
        launch(blk, IV);
        watch(lat, bc, dc);
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL %s_latency: got %0d want 65", name, lat); end
        n_cmp++; if (digest_out !== want) begin n_fail++; $display("FAIL %s_digest: got %h want %h", name, digest_out, want); end
        n_cmp++; if (bc !== 65) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 65", name, bc); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", name, dc); end
    endtask

    task automatic test_random();
        logic [511:0] blk;
        logic [255:0] hv;
        logic [255:0] want;
        int lat, bc, dc;
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
            for (int j = 0; j < 8; j++) hv[32*j +: 32] = $urandom;
            want = ref_compress(blk, hv);
            launch(blk, hv);
            watch(lat, bc, dc);
            n_cmp++; if (digest_out !== want) begin n_fail++; $display("FAIL random%0d_digest: got %h want %h", n, digest_out, want); end
            n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL random%0d_latency: got %0d want 65", n, lat); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, dc;
        launch(BLK_ABC, IV);
        lat = 0;
        bc  = busy ? 1 : 0;
        dc  = 0;
        for (int i = 1; i <= 90; i++) begin
            if (i >= 11 && i <= 61) begin
                start = 1'($urandom_range(0, 1));
                for (int j = 0; j < 16; j++) block_in[32*j +: 32] = $urandom;
                for (int j = 0; j < 8; j++) h_in[32*j +: 32] = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            if (busy) bc++;
            if (done) begin
                dc++;
                if (lat == 0) lat = i;
            end
        end
        n_cmp++; if (digest_out !== DIG_ABC) begin n_fail++; $display("FAIL ignore_digest: got %h want %h", digest_out, DIG_ABC); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d want 1", dc); end
        n_cmp++; if (bc !== 65) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d want 65", bc); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL ignore_latency: got %0d want 65", lat); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [255:0] d1, d2;
        t1 = 0; t2 = 0; d1 = 256'h0; d2 = 256'h0;
        block_in = BLK_ABC;
        h_in     = IV;
        start    = 1'b1;
        tick();
        for (int i = 1; i <= 200 && t2 == 0; i++) begin
            if (t1 != 0 && i == t1 + 2) start = 1'b0;
            tick();
            if (done) begin
                if (t1 == 0) begin
                    t1 = i;
                    d1 = digest_out;
                    block_in = BLK_EMPTY;
                end else begin
                    t2 = i;
                    d2 = digest_out;
                end
            end
        end
        start = 1'b0;
        n_cmp++; if (t1 !== 65) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 65", t1); end
        n_cmp++; if (t2 - t1 !== 66) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 66", t2 - t1); end
        n_cmp++; if (d1 !== DIG_ABC) begin n_fail++; $display("FAIL b2b_digest1: got %h want %h", d1, DIG_ABC); end
        n_cmp++; if (d2 !== DIG_EMPTY) begin n_fail++; $display("FAIL b2b_digest2: got %h want %h", d2, DIG_EMPTY); end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_midop_reset();
        int dcnt, nz, lat;
        launch(BLK_ABC, IV);
        for (int i = 0; i < 30; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (digest_out !== 256'h0) begin n_fail++; $display("FAIL midreset_digest: got %h want 0", digest_out); end
        dcnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done) dcnt++;
        end
        n_cmp++; if (dcnt !== 0) begin n_fail++; $display("FAIL midreset_aborted_done: got %0d want 0", dcnt); end
        launch(BLK_EMPTY, IV);
        nz = 0;
        lat = 0;
        for (int i = 1; i <= 80 && lat == 0; i++) begin
            tick();
            if (done) lat = i;
            else if (digest_out !== 256'h0) nz++;
        end
        n_cmp++; if (nz !== 0) begin n_fail++; $display("FAIL midreset_early_digest: got %0d nonzero cycles want 0", nz); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL midreset_latency: got %0d want 65", lat); end
        n_cmp++; if (digest_out !== DIG_EMPTY) begin n_fail++; $display("FAIL midreset_digest_new: got %h want %h", digest_out, DIG_EMPTY); end
    endtask

    initial begin
        test_reset();
        test_vector(BLK_ABC, DIG_ABC, "abc");
        test_vector(BLK_EMPTY, DIG_EMPTY, "empty");
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
